// File: rtl/memory_ctrl.sv
// ---------------------------------------------------------------------------
// memory_ctrl
// Sequencer that turns a simple req/we/addr/wdata request into a timed access
// of an array of 8-bit rows. Each access runs IDLE -> SETUP -> ACCESS -> DONE:
// SETUP drives the operation and data with no row selected, ACCESS holds one
// row select for ACCESS_CYCLES cycles, and DONE pulses ack for one cycle.
// Addresses at or above ROWS skip ACCESS and complete with err.
//
// Parameters
//   ROWS           number of rows driven (2..16)
//   ACCESS_CYCLES  cycles a row select is held per access (1..15)
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst_n     in   synchronous active-low reset
//   req       in   access request, taken only while ready
//   we        in   1 = write, 0 = read (sampled with req)
//   addr      in   row index (sampled with req)
//   wdata     in   write data (sampled with req)
//   ready     out  controller idle
//   ack       out  one-cycle completion pulse
//   rdata     out  read result register
//   err       out  out-of-range flag, valid with ack
//   S         out  one-hot row select
//   op        out  array operation, 1 = write
//   row_din   out  data to the array
//   row_dout  in   data from the array
// ---------------------------------------------------------------------------
module memory_ctrl #(
    parameter int ROWS          = 16,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic            we,
    input  logic [3:0]      addr,
    input  logic [0:7]      wdata,
    output logic            ready,
    output logic            ack,
    output logic [0:7]      rdata,
    output logic            err,
    output logic [0:ROWS-1] S,
    output logic            op,
    output logic [0:7]      row_din,
    input  logic [0:7]      row_dout
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic       we_q;
    logic [3:0] addr_q;
    logic [0:7] wdata_q;
    logic [3:0] cnt;
    logic       in_range;
    logic       cnt_last;

    // The address is widened by one bit so ROWS = 16 compares correctly.
    assign in_range = ({1'b0, addr_q} < 5'(ROWS));
    assign cnt_last = (cnt == CNT_LAST);

    // State register, request latches, access counter and read register.
    // The request fields are only captured in IDLE, so anything on the
    // inputs while busy cannot disturb an access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 4'd0;
            wdata_q <= 8'h00;
            cnt     <= 4'd0;
            rdata   <= 8'h00;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                    end
                end
                SETUP: begin
                    cnt <= 4'd0;
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    // row_dout is only trusted on the final select cycle of a read.
                    if (cnt_last && !we_q) begin
                        rdata <= row_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode. Everything defaults to the idle/inactive
    // value so S, op and row_din are zero in any state that does not drive them.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        ack        = 1'b0;
        err        = 1'b0;
        S          = '0;
        op         = 1'b0;
        row_din    = 8'h00;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                op      = we_q;
                row_din = we_q ? wdata_q : 8'h00;
                state_next = in_range ? ACCESS : DONE;
            end
            ACCESS: begin
                op      = we_q;
                row_din = we_q ? wdata_q : 8'h00;
                for (int i = 0; i < ROWS; i++) begin
                    S[i] = (addr_q == 4'(i));
                end
                if (cnt_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ack        = 1'b1;
                err        = !in_range;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_memory_ctrl
// Directed bench for memory_ctrl. The main instance (ROWS=16, ACCESS_CYCLES=2)
// drives a small behavioural row array; three more instances cover ROWS=12
// and ACCESS_CYCLES of 1 and 4, reading a fixed data pattern.
// ---------------------------------------------------------------------------
module tb_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [3:0]  addr;
    logic [0:7]  wdata;
    logic [0:7]  aux_dout = 8'h5A;
    logic        mem_clear;

    // main instance
    logic        req;
    logic        ready, ack, err, op;
    logic [0:7]  rdata, row_din, row_dout;
    logic [0:15] S;

    // ROWS = 12 instance
    logic        req_r12;
    logic        ready_r12, ack_r12, err_r12, op_r12;
    logic [0:7]  rdata_r12, row_din_r12;
    logic [0:11] S_r12;

    // ACCESS_CYCLES = 1 instance
    logic        req_a1;
    logic        ready_a1, ack_a1, err_a1, op_a1;
    logic [0:7]  rdata_a1, row_din_a1;
    logic [0:15] S_a1;

    // ACCESS_CYCLES = 4 instance
    logic        req_a4;
    logic        ready_a4, ack_a4, err_a4, op_a4;
    logic [0:7]  rdata_a4, row_din_a4;
    logic [0:15] S_a4;

    logic [0:7]  mem [0:15];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_ctrl #(.ROWS(16), .ACCESS_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .ack(ack), .rdata(rdata), .err(err), .S(S), .op(op),
        .row_din(row_din), .row_dout(row_dout)
    );

    memory_ctrl #(.ROWS(12), .ACCESS_CYCLES(2)) dut_r12 (
        .clk(clk), .rst_n(rst_n), .req(req_r12), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready_r12), .ack(ack_r12), .rdata(rdata_r12), .err(err_r12), .S(S_r12),
        .op(op_r12), .row_din(row_din_r12), .row_dout(aux_dout)
    );

    memory_ctrl #(.ROWS(16), .ACCESS_CYCLES(1)) dut_a1 (
        .clk(clk), .rst_n(rst_n), .req(req_a1), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready_a1), .ack(ack_a1), .rdata(rdata_a1), .err(err_a1), .S(S_a1),
        .op(op_a1), .row_din(row_din_a1), .row_dout(aux_dout)
    );

    memory_ctrl #(.ROWS(16), .ACCESS_CYCLES(4)) dut_a4 (
        .clk(clk), .rst_n(rst_n), .req(req_a4), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready_a4), .ack(ack_a4), .rdata(rdata_a4), .err(err_a4), .S(S_a4),
        .op(op_a4), .row_din(row_din_a4), .row_dout(aux_dout)
    );

    // Behavioural row array for the main instance: the selected row is
    // presented on row_dout and written on the edge while op is high.
    always_comb begin
        row_dout = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (S[i]) row_dout = mem[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (mem_clear) mem[i] <= 8'h00;
            else if (op && S[i]) mem[i] <= row_din;
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [0:15] onehot(input int i);
        logic [0:15] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [0:7] d);
        req   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        req = 1'b0;
        repeat (4) tick();
    endtask

    int         ack_count;
    int         ack_first;
    int         ack_second;
    int         ack_idx_a1;
    int         ack_idx_a4;
    logic       overlap;
    logic [0:7] rd_first;
    logic [0:7] rd_second;

    initial begin
        rst_n     = 1'b0;
        mem_clear = 1'b1;
        req       = 1'b1;
        req_r12   = 1'b1;
        req_a1    = 1'b0;
        req_a4    = 1'b0;
        we        = 1'b1;
        addr      = 4'd5;
        wdata     = 8'hEE;

        // Reset with req held high: nothing may be accepted.
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'h00);
        check("rst_S", 32'(S), 32'd0);
        check("rst_op", 32'(op), 32'd0);
        check("rst_row_din", 32'(row_din), 32'h00);
        check("rst_r12_ready", 32'(ready_r12), 32'd1);
        req       = 1'b0;
        req_r12   = 1'b0;
        rst_n     = 1'b1;
        mem_clear = 1'b0;
        tick();
        check("post_rst_ready", 32'(ready), 32'd1);

        // Write 0xA5 to row 5.
        req = 1'b1; we = 1'b1; addr = 4'd5; wdata = 8'hA5;
        tick();
        req = 1'b0;
        check("wr_setup_ready", 32'(ready), 32'd0);
        check("wr_setup_S", 32'(S), 32'd0);
        check("wr_setup_op", 32'(op), 32'd1);
        check("wr_setup_din", 32'(row_din), 32'hA5);
        tick();
        check("wr_acc0_S", 32'(S), 32'(onehot(5)));
        check("wr_acc0_op", 32'(op), 32'd1);
        tick();
        check("wr_acc1_S", 32'(S), 32'(onehot(5)));
        check("wr_acc1_ack", 32'(ack), 32'd0);
        tick();
        check("wr_done_ack", 32'(ack), 32'd1);
        check("wr_done_S", 32'(S), 32'd0);
        check("wr_done_op", 32'(op), 32'd0);
        check("wr_done_err", 32'(err), 32'd0);
        check("wr_done_din", 32'(row_din), 32'h00);
        tick();
        check("wr_idle_ready", 32'(ready), 32'd1);
        check("wr_mem5", 32'(mem[5]), 32'hA5);

        // Read row 5 back.
        req = 1'b1; we = 1'b0; addr = 4'd5; wdata = 8'h00;
        tick();
        req = 1'b0;
        check("rd_setup_op", 32'(op), 32'd0);
        check("rd_setup_din", 32'(row_din), 32'h00);
        tick();
        check("rd_acc0_S", 32'(S), 32'(onehot(5)));
        check("rd_acc0_op", 32'(op), 32'd0);
        tick();
        check("rd_acc1_S", 32'(S), 32'(onehot(5)));
        tick();
        check("rd_done_ack", 32'(ack), 32'd1);
        check("rd_done_rdata", 32'(rdata), 32'hA5);
        tick();
        check("rd_idle_ack", 32'(ack), 32'd0);

        // Fill rows 0 and 15, then read them back-to-back with req held.
        do_write(4'd0, 8'h11);
        do_write(4'd15, 8'hF0);
        ack_count = 0; ack_first = -1; ack_second = -1; overlap = 1'b0;
        rd_first = 8'h00; rd_second = 8'h00;
        req = 1'b1; we = 1'b0; addr = 4'd0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) addr = 4'd15;
            if (i == 6) req = 1'b0;
            if (S[0] && S[15]) overlap = 1'b1;
            if (ack) begin
                ack_count++;
                if (ack_count == 1) begin
                    ack_first = i;
                    rd_first  = rdata;
                end else begin
                    ack_second = i;
                    rd_second  = rdata;
                end
            end
        end
        check("b2b_ack_count", 32'(ack_count), 32'd2);
        check("b2b_first_ack", 32'(ack_first), 32'd4);
        check("b2b_ack_gap", 32'(ack_second - ack_first), 32'd5);
        check("b2b_overlap", 32'(overlap), 32'd0);
        check("b2b_rdata0", 32'(rd_first), 32'h11);
        check("b2b_rdata15", 32'(rd_second), 32'hF0);

        // Write 0x3C to row 3 while the inputs are churned during ACCESS.
        ack_count = 0;
        req = 1'b1; we = 1'b1; addr = 4'd3; wdata = 8'h3C;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (ack) ack_count++;
            if (i == 3) begin
                check("busy_S", 32'(S), 32'(onehot(3)));
                check("busy_din", 32'(row_din), 32'h3C);
            end
            case (i)
                1: req = 1'b0;
                2: begin req = 1'b1; addr = 4'd7; wdata = 8'hFF; end
                3: begin req = 1'b0; addr = 4'd9; wdata = 8'h00; end
                default: begin end
            endcase
        end
        check("busy_ack_count", 32'(ack_count), 32'd1);
        check("busy_mem3", 32'(mem[3]), 32'h3C);
        check("busy_mem7", 32'(mem[7]), 32'h00);
        check("busy_mem9", 32'(mem[9]), 32'h00);
        check("busy_mem5", 32'(mem[5]), 32'hA5);

        // Abort a write to row 6 with reset in its first ACCESS cycle.
        req = 1'b1; we = 1'b1; addr = 4'd6; wdata = 8'h77;
        tick();
        req = 1'b0;
        tick();
        check("abort_acc_S", 32'(S), 32'(onehot(6)));
        check("abort_acc_op", 32'(op), 32'd1);
        rst_n = 1'b0;
        tick();
        check("abort_S", 32'(S), 32'd0);
        check("abort_op", 32'(op), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_rdata", 32'(rdata), 32'h00);
        rst_n = 1'b1;
        ack_count = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack) ack_count++;
        end
        check("abort_no_ack", 32'(ack_count), 32'd0);

        // ROWS = 12: a good read first, then out-of-range addr 13.
        req_r12 = 1'b1; we = 1'b0; addr = 4'd2;
        tick();
        req_r12 = 1'b0;
        repeat (3) tick();
        check("r12_rd_ack", 32'(ack_r12), 32'd1);
        check("r12_rd_rdata", 32'(rdata_r12), 32'h5A);
        tick();
        req_r12 = 1'b1; we = 1'b0; addr = 4'd13;
        tick();
        req_r12 = 1'b0;
        check("oor_setup_S", 32'(S_r12), 32'd0);
        check("oor_setup_ack", 32'(ack_r12), 32'd0);
        check("oor_setup_err", 32'(err_r12), 32'd0);
        check("oor_setup_ready", 32'(ready_r12), 32'd0);
        tick();
        check("oor_done_ack", 32'(ack_r12), 32'd1);
        check("oor_done_err", 32'(err_r12), 32'd1);
        check("oor_done_S", 32'(S_r12), 32'd0);
        check("oor_done_rdata", 32'(rdata_r12), 32'h5A);
        check("oor_done_op", 32'(op_r12), 32'd0);
        tick();
        check("oor_idle_err", 32'(err_r12), 32'd0);
        check("oor_idle_ready", 32'(ready_r12), 32'd1);
        check("oor_idle_din", 32'(row_din_r12), 32'h00);

        // Latency sweep on ACCESS_CYCLES = 1 and 4.
        ack_idx_a1 = -1; ack_idx_a4 = -1;
        req_a1 = 1'b1; req_a4 = 1'b1; we = 1'b0; addr = 4'd1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1) begin
                req_a1 = 1'b0;
                req_a4 = 1'b0;
            end
            if (ack_a1 && ack_idx_a1 < 0) ack_idx_a1 = i;
            if (ack_a4 && ack_idx_a4 < 0) ack_idx_a4 = i;
        end
        check("lat_a1", 32'(ack_idx_a1), 32'd3);
        check("lat_a4", 32'(ack_idx_a4), 32'd6);
        check("lat_a1_rdata", 32'(rdata_a1), 32'h5A);
        check("lat_a4_rdata", 32'(rdata_a4), 32'h5A);
        check("lat_a1_ready", 32'(ready_a1), 32'd1);
        check("lat_a4_ready", 32'(ready_a4), 32'd1);
        check("lat_a1_idle", 32'({S_a1, op_a1, err_a1, row_din_a1}), 32'd0);
        check("lat_a4_idle", 32'({S_a4, op_a4, err_a4, row_din_a4}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_ctrl.md
MEMORY_CTRL -- requirements
Module: memory_ctrl

Interface
REQ-001 Parameter: ROWS, 16, number of 8-bit memory rows driven; legal range 2..16.
REQ-002 Parameter: ACCESS_CYCLES, 2, cycles the row select is held per access; legal range 1..15.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 Port: req  in  1  access request, qualified by ready.
REQ-006 Port: we  in  1  1 = write, 0 = read; sampled with req.
REQ-007 Port: addr  in  4  row index; sampled with req.
REQ-008 Port: wdata  in  8 ([0:7])  write data; sampled with req.
REQ-009 Port: ready  out  1  controller idle; can accept a request.
REQ-010 Port: ack  out  1  one-cycle completion pulse.
REQ-011 Port: rdata  out  8 ([0:7])  read result register.
REQ-012 Port: err  out  1  out-of-range address flag, valid with ack.
REQ-013 Port: S  out  ROWS ([0:ROWS-1])  one-hot row select to the row array.
REQ-014 Port: op  out  1  array operation; 1 = write, 0 = read/hold.
REQ-015 Port: row_din  out  8 ([0:7])  data bus to the array data_input.
REQ-016 Port: row_dout  in  8 ([0:7])  data bus from the array data_output.

Function
REQ-017 The FSM SHALL have the states IDLE, SETUP, ACCESS and DONE.
REQ-018 IDLE: ready=1; on req=1, latch we, addr and wdata, then go to SETUP; otherwise stay in IDLE.
REQ-019 SETUP lasts one cycle with S all-zero:
- row_din = latched wdata if write, else 0.
- op = latched we.
- If addr >= ROWS, go to DONE with err set; otherwise go to ACCESS with the cycle counter loaded to 0.
REQ-020 ACCESS holds S[addr]=1 and all other S bits at 0 for exactly ACCESS_CYCLES cycles:
- op and row_din are held stable.
- The counter increments each cycle.
- The FSM moves to DONE when counter = ACCESS_CYCLES-1.
REQ-021 Read: rdata SHALL load from row_dout on the edge that leaves ACCESS. rdata SHALL be unchanged on writes and on errors.
REQ-022 DONE lasts one cycle:
- ack=1.
- S = 0, op = 0, row_din = 0.
- err = 1 only if the request was out of range.
- Then return to IDLE.
REQ-023 Latency: if req is accepted at edge k, ack is high in cycle k+2+ACCESS_CYCLES (4 cycles with the defaults). The out-of-range path acks in cycle k+2.
REQ-024 ready SHALL be 0 in SETUP, ACCESS and DONE. req in those states is ignored, and the latched fields do not change.
REQ-025 A req held high through DONE SHALL be accepted in the following IDLE cycle, so back-to-back accesses have one idle cycle between them.
REQ-026 At most one S bit SHALL be high in any cycle. S SHALL be all-zero outside ACCESS.
REQ-027 op SHALL be 1 only in SETUP/ACCESS of a write. A write SHALL never overlap a select of a different row.
REQ-028 err SHALL be 0 in every cycle except the DONE cycle of an out-of-range request.
REQ-029 row_dout SHALL be ignored in every cycle except the final ACCESS cycle of a read.

Reset
REQ-030 With rst_n=0 at an edge, the block SHALL enter IDLE with:
- ready=1, ack=0, err=0.
- rdata=0, S=0, op=0, row_din=0.
- counter=0.
REQ-031 Reset asserted mid-access SHALL abort the operation at that edge: S and op are low in the next cycle, and no ack is issued for the aborted request.
REQ-032 req asserted during reset SHALL be ignored. The first acceptance is the first edge with rst_n=1 and req=1.

Verification
REQ-033 Write then read: write addr=5, wdata=0xA5, then read addr=5. Required: S[5] is high for 2 cycles each time; op=1 only during the write; ack is seen twice; rdata=0xA5 after the read.
REQ-034 Out of range: with ROWS=12, request addr=13. Required: S stays all-zero; ack and err are 1 together 2 cycles after acceptance; rdata is unchanged.
REQ-035 Back-to-back: hold req=1 for reads of addr=0 then addr=15. Required: acks 5 cycles apart; S[0] and S[15] are never high together; rdata follows row_dout.
REQ-036 Busy ignore: toggle req, addr and wdata during ACCESS of a write to addr=3 (0x3C). Required: only row 3 is written, with 0x3C; exactly one ack.
REQ-037 Reset abort: drive rst_n=0 in the first ACCESS cycle of a write. Required: S=0, op=0 and ready=1 next cycle; no ack; rdata=0.
REQ-038 Latency sweep: with ACCESS_CYCLES=1 and ACCESS_CYCLES=4, ack occurs 3 and 6 cycles after acceptance respectively.
